// File: rtl/musb_bus_pkg.sv
// Shared definitions for the multi-master bus arbiter: arbitration mode names,
// FSM state encoding and a width helper usable in parameter expressions.
package musb_bus_pkg;

    localparam string ARB_RR    = "RR";
    localparam string ARB_FIXED = "FIXED";

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Never returns less than 1 so a 1-entry range still gets a real bit.
    function automatic int musb_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/musb_rr_encoder.sv
// Picks the winning requester: lowest index in fixed mode, otherwise the first
// requester found scanning upward from last_grant+1 with wrap. Purely combinational.
module musb_rr_encoder
    import musb_bus_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = musb_clog2(N)
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] last_grant,
    input  logic          fixed_mode,
    output logic          valid,
    output logic [IW-1:0] index
);

    function automatic logic [IW-1:0] slot(input logic [IW-1:0] last, input int off,
                                            input logic fixed);
        int s;
        s = fixed ? off : (int'(last) + 1 + off) % N;
        return IW'(s);
    endfunction

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (!valid && request[slot(last_grant, i, fixed_mode)]) begin
                valid = 1'b1;
                index = slot(last_grant, i, fixed_mode);
            end
        end
    end

endmodule

// File: rtl/musb_bus_arbiter.sv
// N-master to single-slave bus arbiter; grant registered in IDLE, slave request
// is combinational in BUSY, one forced IDLE turnaround after every transfer.
module musb_bus_arbiter
    import musb_bus_pkg::*;
#(
    parameter int    N_MASTERS  = 3,
    parameter int    ADDR_WIDTH = 32,
    parameter int    DATA_WIDTH = 32,
    parameter string ARB_MODE   = "RR",
    parameter int    TIMEOUT    = 255,
    localparam int   WR_WIDTH   = DATA_WIDTH / 8,
    localparam int   GW         = musb_clog2(N_MASTERS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] master_address,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] master_data_i,
    input  logic [N_MASTERS*WR_WIDTH-1:0]   master_wr,
    input  logic [N_MASTERS-1:0]            master_enable,
    output logic [DATA_WIDTH-1:0]           master_data_o,
    output logic [N_MASTERS-1:0]            master_ready,
    output logic [N_MASTERS-1:0]            master_error,
    input  logic [DATA_WIDTH-1:0]           slave_data_i,
    input  logic                            slave_ready,
    input  logic                            slave_error,
    output logic [ADDR_WIDTH-1:0]           slave_address,
    output logic [DATA_WIDTH-1:0]           slave_data_o,
    output logic [WR_WIDTH-1:0]             slave_wr,
    output logic                            slave_enable,
    output logic [GW-1:0]                   grant_id,
    output logic                            busy
);

    localparam int   CW         = musb_clog2(TIMEOUT + 1);
    localparam logic FIXED_MODE = (ARB_MODE == ARB_FIXED);

    arb_state_t    state, state_nxt;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] last_grant, last_nxt;
    logic [CW-1:0] tcnt, tcnt_nxt;
    logic          enc_valid;
    logic [GW-1:0] enc_index;
    logic          sel_en;
    logic          timeout_hit;
    logic          rdy_ok;
    logic          err_hit;

    musb_rr_encoder #(
        .N  (N_MASTERS),
        .IW (GW)
    ) u_enc (
        .request    (master_enable),
        .last_grant (last_grant),
        .fixed_mode (FIXED_MODE),
        .valid      (enc_valid),
        .index      (enc_index)
    );

    assign busy          = (state == ST_BUSY);
    assign master_data_o = slave_data_i;

    // The counter parks at TIMEOUT-1; with TIMEOUT==0 the first term kills the hit.
    assign timeout_hit = (TIMEOUT != 0) && busy && (tcnt == CW'(TIMEOUT - 1));
    assign rdy_ok      = slave_ready & ~slave_error;
    assign err_hit     = slave_error | (timeout_hit & ~slave_ready);

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_id;
        last_nxt      = last_grant;
        tcnt_nxt      = tcnt;
        slave_address = '0;
        slave_data_o  = '0;
        slave_wr      = '0;
        slave_enable  = 1'b0;
        master_ready  = '0;
        master_error  = '0;
        sel_en        = 1'b0;

        for (int g = 0; g < N_MASTERS; g++) begin
            if (busy && (GW'(g) == grant_id)) begin
                slave_address   = master_address[g*ADDR_WIDTH +: ADDR_WIDTH];
                slave_data_o    = master_data_i[g*DATA_WIDTH +: DATA_WIDTH];
                slave_wr        = master_wr[g*WR_WIDTH +: WR_WIDTH];
                sel_en          = master_enable[g];
                slave_enable    = master_enable[g];
                // A master that withdrew its request gets no strobe at all.
                master_ready[g] = master_enable[g] & rdy_ok;
                master_error[g] = master_enable[g] & err_hit;
            end
        end

        case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_nxt = ST_BUSY;
                    grant_nxt = enc_index;
                    tcnt_nxt  = '0;
                end
            end
            ST_BUSY: begin
                if (!sel_en || slave_ready || slave_error || timeout_hit) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = grant_id;
                end else if (tcnt != CW'(TIMEOUT - 1)) begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= GW'(N_MASTERS - 1);
            tcnt       <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
            tcnt       <= tcnt_nxt;
        end
    end

endmodule

// File: tb/tb_musb_bus_arbiter.sv
// Drives a round-robin (TIMEOUT=4) and a fixed-priority (no timeout) arbiter with
// the same master/slave stimulus and compares both against a transaction-level model.
module tb_musb_bus_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     addr_a [N];
    logic [31:0]     dat_a  [N];
    logic [3:0]      wr_a   [N];
    logic [N-1:0]    en_v;
    logic [31:0]     sdi;
    logic            sr, se;
    logic [N*32-1:0] m_addr, m_dat;
    logic [N*4-1:0]  m_wr;

    logic [31:0]     o_mdo [2];
    logic [31:0]     o_saddr [2];
    logic [31:0]     o_sdo [2];
    logic [3:0]      o_swr [2];
    logic            o_sen [2];
    logic            o_busy [2];
    logic [N-1:0]    o_rdy [2];
    logic [N-1:0]    o_err [2];
    logic [1:0]      o_gid [2];

    logic            s_busy [2];
    logic [1:0]      s_gid [2];
    logic [N-1:0]    s_rdy [2];
    logic [N-1:0]    s_err [2];

    bit              m_busy [2];
    int              m_owner [2];
    int              m_last [2];
    int              m_wait [2];

    int              n_checks = 0;
    int              n_errors = 0;
    int              rr_q [$];

    always #5 clk = ~clk;

    assign m_addr = {addr_a[2], addr_a[1], addr_a[0]};
    assign m_dat  = {dat_a[2], dat_a[1], dat_a[0]};
    assign m_wr   = {wr_a[2], wr_a[1], wr_a[0]};

    musb_bus_arbiter #(
        .N_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE("RR"), .TIMEOUT(4)
    ) dut_rr (
        .clk(clk), .rst(rst_n),
        .master_address(m_addr), .master_data_i(m_dat), .master_wr(m_wr),
        .master_enable(en_v), .master_data_o(o_mdo[0]),
        .master_ready(o_rdy[0]), .master_error(o_err[0]),
        .slave_data_i(sdi), .slave_ready(sr), .slave_error(se),
        .slave_address(o_saddr[0]), .slave_data_o(o_sdo[0]), .slave_wr(o_swr[0]),
        .slave_enable(o_sen[0]), .grant_id(o_gid[0]), .busy(o_busy[0])
    );

    musb_bus_arbiter #(
        .N_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE("FIXED"), .TIMEOUT(0)
    ) dut_fx (
        .clk(clk), .rst(rst_n),
        .master_address(m_addr), .master_data_i(m_dat), .master_wr(m_wr),
        .master_enable(en_v), .master_data_o(o_mdo[1]),
        .master_ready(o_rdy[1]), .master_error(o_err[1]),
        .slave_data_i(sdi), .slave_ready(sr), .slave_error(se),
        .slave_address(o_saddr[1]), .slave_data_o(o_sdo[1]), .slave_wr(o_swr[1]),
        .slave_enable(o_sen[1]), .grant_id(o_gid[1]), .busy(o_busy[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input string s, input int k);
        return $sformatf("%s_%s", s, (k == 0) ? "rr" : "fx");
    endfunction

    function automatic int tmo(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    // Winner = requester closest after the previous owner on the ring, or simply
    // the lowest requester when priorities are fixed.
    function automatic int pick(input bit fixed, input int last, input logic [N-1:0] req);
        int best, best_d, d;
        best   = -1;
        best_d = N + 1;
        for (int m = 0; m < N; m++) begin
            if (req[m]) begin
                d = fixed ? m : (m - last - 1 + 2 * N) % N;
                if (d < best_d) begin
                    best_d = d;
                    best   = m;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 1'b0;
            m_owner[k] = 0;
            m_last[k]  = N - 1;
            m_wait[k]  = 0;
        end
    endtask

    // Called just after a falling edge with inputs applied; checks this cycle's
    // outputs, advances the model across the next rising edge.
    task automatic step();
        logic [N-1:0] er, ee;
        bit           en, to;
        int           o, p;
        #2;
        for (int k = 0; k < 2; k++) begin
            o  = m_owner[k];
            en = m_busy[k] && en_v[o];
            to = (tmo(k) != 0) && m_busy[k] && (m_wait[k] == tmo(k) - 1);
            er = '0;
            ee = '0;
            if (en && sr && !se) er[o] = 1'b1;
            if (en && (se || (to && !sr))) ee[o] = 1'b1;

            check_eq(tg("busy", k), o_busy[k], m_busy[k]);
            check_eq(tg("slave_enable", k), o_sen[k], en);
            check_eq(tg("ready", k), o_rdy[k], er);
            check_eq(tg("error", k), o_err[k], ee);
            check_eq(tg("rdata", k), o_mdo[k], sdi);
            if (m_busy[k]) begin
                check_eq(tg("grant", k), o_gid[k], o);
                check_eq(tg("saddr", k), o_saddr[k], addr_a[o]);
                check_eq(tg("sdata", k), o_sdo[k], dat_a[o]);
                check_eq(tg("swr", k), o_swr[k], wr_a[o]);
            end
            s_busy[k] = o_busy[k];
            s_gid[k]  = o_gid[k];
            s_rdy[k]  = o_rdy[k];
            s_err[k]  = o_err[k];

            if (!rst_n) begin
                m_busy[k]  = 1'b0;
                m_owner[k] = 0;
                m_last[k]  = N - 1;
                m_wait[k]  = 0;
            end else if (!m_busy[k]) begin
                p = pick(k == 1, m_last[k], en_v);
                if (p >= 0) begin
                    m_busy[k]  = 1'b1;
                    m_owner[k] = p;
                    m_wait[k]  = 0;
                end
            end else if (!en_v[o] || sr || se || to) begin
                m_busy[k] = 1'b0;
                m_last[k] = o;
            end else begin
                m_wait[k]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_v  = '0;
        sr    = 1'b0;
        se    = 1'b0;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            check_eq(tg("rst_busy", k), s_busy[k], 1'b0);
            check_eq(tg("rst_grant", k), s_gid[k], 2'd0);
            check_eq(tg("rst_ready", k), s_rdy[k], 3'b000);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en_v  = '0;
        sr    = 1'b0;
        se    = 1'b0;
        sdi   = 32'h0;
        for (int m = 0; m < N; m++) begin
            addr_a[m] = 32'h1000 * (m + 1);
            dat_a[m]  = 32'hA5A5_0000 + m;
            wr_a[m]   = 4'(m);
        end
        model_reset();
        @(negedge clk);

        // Everyone requests continuously against a zero-wait slave.
        do_reset();
        en_v = 3'b111;
        sr   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sdi = $urandom;
            step();
            if (s_busy[0]) rr_q.push_back(int'(s_gid[0]));
            if (s_busy[1]) check_eq("fx_starve", s_gid[1], 2'd0);
            check_eq("rr_ready_pulse", (s_rdy[0] != 0), (i % 2) == 1);
        end
        check_eq("rr_order_len", rr_q.size(), 6);
        for (int j = 0; j < 6; j++)
            check_eq("rr_order", (j < rr_q.size()) ? rr_q[j] : 99, j % 3);

        // Stalled slave: timeout, then ready+error together, then ready on timeout.
        do_reset();
        en_v = 3'b111;
        for (int i = 0; i < 12; i++) begin
            sr = (i == 6) || (i == 11);
            se = (i == 6);
            step();
            if (i == 4) begin
                check_eq("to_err", s_err[0], 3'b001);
                check_eq("fx_no_timeout", s_err[1], 3'b000);
                check_eq("fx_still_busy", s_busy[1], 1'b1);
            end
            if (i == 5) check_eq("to_turnaround", s_busy[0], 1'b0);
            if (i == 6) begin
                check_eq("err_wins_err", s_err[0], 3'b010);
                check_eq("err_wins_rdy", s_rdy[0], 3'b000);
            end
            if (i == 11) begin
                check_eq("rdy_wins_rdy", s_rdy[0], 3'b100);
                check_eq("rdy_wins_err", s_err[0], 3'b000);
            end
        end

        // Master 1 withdraws in its second BUSY cycle, then reset lands mid-transfer.
        do_reset();
        en_v = 3'b001;
        sr   = 1'b1;
        se   = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j == 2) begin
                en_v = 3'b110;
                sr   = 1'b0;
            end
            if (j == 4) en_v = 3'b100;
            if (j == 7) rst_n = 1'b0;
            if (j == 8) begin
                rst_n = 1'b1;
                en_v  = 3'b111;
            end
            step();
            if (j == 4) begin
                check_eq("abort_busy", s_busy[0], 1'b1);
                check_eq("abort_rdy", s_rdy[0], 3'b000);
                check_eq("abort_err", s_err[0], 3'b000);
            end
            if (j == 6) check_eq("abort_next_grant", s_gid[0], 2'd2);
            if (j == 8) check_eq("rst_mid_busy", s_busy[0], 1'b0);
            if (j == 9) check_eq("rst_first_grant", s_gid[0], 2'd0);
        end

        // Random traffic with occasional withdrawals and resets.
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < N; m++) begin
                if (!en_v[m]) begin
                    if ($urandom_range(2) == 0) begin
                        en_v[m]   = 1'b1;
                        addr_a[m] = $urandom;
                        dat_a[m]  = $urandom;
                        wr_a[m]   = 4'($urandom);
                    end
                end else if ($urandom_range(9) == 0) begin
                    en_v[m] = 1'b0;
                end
            end
            sr    = ($urandom_range(2) == 0);
            se    = ($urandom_range(7) == 0);
            sdi   = $urandom;
            rst_n = ($urandom_range(49) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
